// File: rtl/pkt_asm_pkg.sv
// Shared types and width helpers for the packet assembler and its FIFO.
// Optional statistics counter in the top is enabled by PKT_ASSEMBLER_STATS_EN.
package pkt_asm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  localparam int DROP_CNT_W = 8;
  localparam int PKT_CNT_W  = 16;

  function automatic int id_w(input int pkt_num);
    return (pkt_num > 1) ? $clog2(pkt_num) : 1;
  endfunction

  function automatic int beat_cnt_w(input int pkt_size);
    return $clog2(pkt_size + 1);
  endfunction

endpackage

// File: rtl/pkt_asm_fifo.sv
// Show-ahead FIFO: head entry is visible on rdata whenever not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pkt_asm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gate the head with empty so the output reads zero after reset and when drained.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pkt_assembler.sv
// Collapses PKT_SIZE-beat packets into wide words, queues them, flags framing errors.
// Define PKT_ASSEMBLER_STATS_EN to enable the pkt_cnt packet counter.
module pkt_assembler
  import pkt_asm_pkg::*;
#(
  parameter int PKT_NUM    = 7,
  parameter int PKT_SIZE   = 3,
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           vld_in,
  input  logic                           SOP_in,
  input  logic                           EOP_in,
  input  logic [id_w(PKT_NUM)-1:0]       pkt_id_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [id_w(PKT_NUM)-1:0]       out_pkt_id,
  output logic [PKT_SIZE*DATA_WIDTH-1:0] out_data,
  input  logic                           err_clr,
  output logic                           err_seq,
  output logic                           err_id,
  output logic                           err_len,
  output logic [DROP_CNT_W-1:0]          drop_cnt,
  output logic [PKT_CNT_W-1:0]           pkt_cnt
);

  localparam int ID_W = id_w(PKT_NUM);
  localparam int BCW  = beat_cnt_w(PKT_SIZE);
  localparam int PW   = PKT_SIZE * DATA_WIDTH;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(PKT_SIZE - 1);

  state_t          state_q, state_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic            err_seq_q, err_seq_d;
  logic            err_id_q, err_id_d;
  logic            err_len_q, err_len_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic seq_evt, id_evt, len_evt, push_req, push_ok, pop, drop;
  logic fifo_full, fifo_empty;
  logic [ID_W+PW-1:0] fifo_rdata;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    cur_id_d   = cur_id_q;
    buf_d      = buf_q;
    seq_evt    = 1'b0;
    id_evt     = 1'b0;
    len_evt    = 1'b0;
    push_req   = 1'b0;
    if (vld_in) begin
      case (state_q)
        IDLE: begin
          if (!SOP_in) begin
            seq_evt = 1'b1;
          end else if (EOP_in) begin
            len_evt = 1'b1;
          end else begin
            buf_d[0 +: DATA_WIDTH] = data_in;
            cur_id_d   = pkt_id_in;
            beat_cnt_d = BCW'(1);
            state_d    = BODY;
          end
        end
        BODY: begin
          if (SOP_in) begin
            // A fresh SOP restarts assembly; a single-beat SOP+EOP is also a length fault.
            seq_evt = 1'b1;
            if (EOP_in) begin
              len_evt    = 1'b1;
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              buf_d[0 +: DATA_WIDTH] = data_in;
              cur_id_d   = pkt_id_in;
              beat_cnt_d = BCW'(1);
            end
          end else if (pkt_id_in != cur_id_q) begin
            id_evt     = 1'b1;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else if (!EOP_in) begin
            if (beat_cnt_q == LAST_IDX) begin
              len_evt    = 1'b1;
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              buf_d[int'(beat_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = data_in;
              beat_cnt_d = beat_cnt_q + BCW'(1);
            end
          end else begin
            if (beat_cnt_q != LAST_IDX) begin
              len_evt = 1'b1;
            end else begin
              buf_d[int'(LAST_IDX)*DATA_WIDTH +: DATA_WIDTH] = data_in;
              push_req = 1'b1;
            end
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop     = out_vld & out_rdy;
  assign push_ok = push_req & (~fifo_full | pop);
  assign drop    = push_req & ~push_ok;

  always_comb begin
    // An error event in the clear cycle keeps the bit set.
    err_seq_d  = (err_seq_q & ~err_clr) | seq_evt;
    err_id_d   = (err_id_q  & ~err_clr) | id_evt;
    err_len_d  = (err_len_q & ~err_clr) | len_evt;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      cur_id_q   <= '0;
      buf_q      <= '0;
      err_seq_q  <= 1'b0;
      err_id_q   <= 1'b0;
      err_len_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      cur_id_q   <= cur_id_d;
      buf_q      <= buf_d;
      err_seq_q  <= err_seq_d;
      err_id_q   <= err_id_d;
      err_len_q  <= err_len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  pkt_asm_fifo #(
    .WIDTH (ID_W + PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata ({cur_id_q, buf_d}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_vld    = ~fifo_empty;
  assign out_pkt_id = fifo_rdata[PW +: ID_W];
  assign out_data   = fifo_rdata[PW-1:0];
  assign err_seq    = err_seq_q;
  assign err_id     = err_id_q;
  assign err_len    = err_len_q;
  assign drop_cnt   = drop_cnt_q;

`ifdef PKT_ASSEMBLER_STATS_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push_ok) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_assembler.sv
// Self-checking bench for pkt_assembler: packet table, scoreboard on the output side,
// and hand-written sequences for overflow, framing errors and mid-packet reset.
module tb_pkt_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_in = 1'b0, SOP_in = 1'b0, EOP_in = 1'b0;
  logic [2:0] pkt_id_in = '0;
  logic       data_in = 1'b0;
  logic       out_vld;
  logic       out_rdy = 1'b0;
  logic [2:0] out_pkt_id;
  logic [2:0] out_data;
  logic       err_clr = 1'b0;
  logic       err_seq, err_id, err_len;
  logic [7:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  logic [5:0] sb [$];

  typedef struct {
    logic [2:0] id;
    logic       d0, d1, d2;
    logic [2:0] exp_data;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  pkt_assembler dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .SOP_in(SOP_in), .EOP_in(EOP_in),
    .pkt_id_in(pkt_id_in), .data_in(data_in), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_pkt_id(out_pkt_id), .out_data(out_data), .err_clr(err_clr),
    .err_seq(err_seq), .err_id(err_id), .err_len(err_len),
    .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Scoreboard side: a transfer happens at the next posedge when vld & rdy are seen here.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      n_checks++;
      pop_cnt++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL pop: unexpected packet id=%0d data=%b expected none", out_pkt_id, out_data);
      end else if ({out_pkt_id, out_data} !== sb[0]) begin
        n_errors++;
        $display("FAIL pop: got id=%0d data=%b expected id=%0d data=%b",
                 out_pkt_id, out_data, sb[0][5:3], sb[0][2:0]);
        void'(sb.pop_front());
      end else begin
        $display("pop  id=%0d data=%b", out_pkt_id, out_data);
        void'(sb.pop_front());
      end
    end
  end

  task automatic beat(input logic s, input logic e, input logic [2:0] id, input logic d);
    vld_in = 1'b1; SOP_in = s; EOP_in = e; pkt_id_in = id; data_in = d;
    @(posedge clk); #1;
    vld_in = 1'b0; SOP_in = 1'b0; EOP_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] id, input logic [2:0] d);
    beat(1'b1, 1'b0, id, d[0]);
    beat(1'b0, 1'b0, id, d[1]);
    beat(1'b0, 1'b1, id, d[2]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      idle(1);
      k++;
    end
    idle(1);
    check(name, sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{id: 3'd2, d0: 1'b1, d1: 1'b0, d2: 1'b1, exp_data: 3'b101};
    vecs[1] = '{id: 3'd0, d0: 1'b1, d1: 1'b1, d2: 1'b0, exp_data: 3'b011};
    vecs[2] = '{id: 3'd6, d0: 1'b0, d1: 1'b0, d2: 1'b1, exp_data: 3'b100};
    vecs[3] = '{id: 3'd5, d0: 1'b0, d1: 1'b1, d2: 1'b0, exp_data: 3'b010};
    vecs[4] = '{id: 3'd3, d0: 1'b1, d1: 1'b1, d2: 1'b1, exp_data: 3'b111};
    vecs[5] = '{id: 3'd1, d0: 1'b0, d1: 1'b0, d2: 1'b0, exp_data: 3'b000};

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset out_vld", out_vld, 0);
    check("reset out_data", out_data, 0);
    check("reset out_pkt_id", out_pkt_id, 0);
    check("reset errs", {err_seq, err_id, err_len}, 0);
    check("reset drop_cnt", drop_cnt, 0);
    check("reset pkt_cnt", pkt_cnt, 0);

    // Clean packet with latency check
    out_rdy = 1'b1;
    beat(1'b1, 1'b0, 3'd2, 1'b1);
    beat(1'b0, 1'b0, 3'd2, 1'b0);
    check("latency vld before EOP", out_vld, 0);
    sb.push_back({3'd2, 3'b101});
    beat(1'b0, 1'b1, 3'd2, 1'b1);
    check("latency vld after EOP", out_vld, 1);
    check("clean out_pkt_id", out_pkt_id, 2);
    check("clean out_data", out_data, 3'b101);
    wait_drain("clean drain");
    check("clean errs", {err_seq, err_id, err_len}, 0);

    // Table-driven back-to-back packets
    for (int i = 0; i < 6; i++) begin
      sb.push_back({vecs[i].id, vecs[i].exp_data});
      send_pkt(vecs[i].id, {vecs[i].d2, vecs[i].d1, vecs[i].d0});
    end
    wait_drain("table drain");
    check("table errs", {err_seq, err_id, err_len}, 0);

    // Overflow: 6 packets into a 4-deep FIFO with no consumer
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sb.push_back({3'(i), 3'(i)});
      send_pkt(3'(i), 3'(i));
    end
    check("overflow drop_cnt", drop_cnt, 2);
    check("overflow head id", out_pkt_id, 0);
    pop_cnt = 0;
    out_rdy = 1'b1;
    wait_drain("overflow drain");
    check("overflow pops", pop_cnt, 4);
    check("overflow vld low", out_vld, 0);

    // Full FIFO with a pop in the EOP cycle of a 5th packet
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({3'(i), 3'(i + 3)});
      send_pkt(3'(i), 3'(i + 3));
    end
    sb.push_back({3'd6, 3'b101});
    beat(1'b1, 1'b0, 3'd6, 1'b1);
    beat(1'b0, 1'b0, 3'd6, 1'b0);
    out_rdy = 1'b1;
    beat(1'b0, 1'b1, 3'd6, 1'b1);
    out_rdy = 1'b0;
    pop_cnt = 0;
    check("full+pop drop_cnt", drop_cnt, 2);
    check("full+pop out_vld", out_vld, 1);
    out_rdy = 1'b1;
    wait_drain("full+pop drain");
    check("full+pop occupancy", pop_cnt, 4);

    // Framing errors
    beat(1'b0, 1'b0, 3'd2, 1'b1);
    check("mop idle err_seq", err_seq, 1);
    check("mop idle err_id/len", {err_id, err_len}, 0);
    clear_errs();
    check("clear err_seq", err_seq, 0);
    beat(1'b1, 1'b0, 3'd1, 1'b0);
    sb.push_back({3'd3, 3'b110});
    beat(1'b1, 1'b0, 3'd3, 1'b0);
    check("sop mid err_seq", err_seq, 1);
    beat(1'b0, 1'b0, 3'd3, 1'b1);
    beat(1'b0, 1'b1, 3'd3, 1'b1);
    wait_drain("sop mid restart drain");
    check("sop mid err_id/len", {err_id, err_len}, 0);
    clear_errs();
    pop_cnt = 0;
    beat(1'b1, 1'b0, 3'd4, 1'b1);
    beat(1'b0, 1'b1, 3'd4, 1'b1);
    idle(2);
    check("early eop err_len", err_len, 1);
    check("early eop no push", pop_cnt, 0);
    clear_errs();
    beat(1'b1, 1'b0, 3'd4, 1'b1);
    beat(1'b0, 1'b0, 3'd5, 1'b1);
    idle(2);
    check("id change err_id", err_id, 1);
    check("id change no push", pop_cnt, 0);
    check("id change err_seq/len", {err_seq, err_len}, 0);
    clear_errs();
    check("sticky clear", {err_seq, err_id, err_len}, 0);
    check("drop_cnt survives clear", drop_cnt, 2);
    err_clr = 1'b1;
    beat(1'b0, 1'b0, 3'd1, 1'b0);
    err_clr = 1'b0;
    check("error wins over clear", err_seq, 1);
    clear_errs();

    // Reset mid-packet with two packets queued
    out_rdy = 1'b0;
    send_pkt(3'd1, 3'b001);
    send_pkt(3'd2, 3'b010);
    beat(1'b1, 1'b0, 3'd4, 1'b1);
    beat(1'b0, 1'b0, 3'd4, 1'b1);
    check("queued before reset", out_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_vld", out_vld, 0);
    check("async reset out_data", out_data, 0);
    sb.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset drop_cnt", drop_cnt, 0);
    // The EOP of the abandoned packet must not complete anything after reset.
    beat(1'b0, 1'b1, 3'd4, 1'b1);
    check("stray eop err_seq", err_seq, 1);
    clear_errs();
    out_rdy = 1'b1;
    sb.push_back({3'd5, 3'b011});
    send_pkt(3'd5, 3'b011);
    wait_drain("post reset drain");
`ifdef PKT_ASSEMBLER_STATS_EN
    check("post reset pkt_cnt", pkt_cnt, 1);
`else
    check("post reset pkt_cnt", pkt_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_assembler.md
Name: pkt_assembler

Overview:
- Sits directly downstream of the packet reorder stage.
- Consumes its serial beat stream (vld/SOP/EOP/data/pkt_id, one beat per cycle, no backpressure) and collapses each PKT_SIZE-beat packet into one wide word.
- Buffers assembled packets in a small FIFO and presents them on a valid/ready interface.
- Flags framing violations with sticky error bits and counts packets dropped on FIFO overflow.

Parameters:
- PKT_NUM, 7, number of packet IDs; ID width = $clog2(PKT_NUM).
- PKT_SIZE, 3, beats per packet (SOP, PKT_SIZE-2 middle, EOP); must be >= 2.
- DATA_WIDTH, 1, bits per beat.
- FIFO_DEPTH, 4, assembled-packet FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- vld_in  in  1  beat valid.
- SOP_in  in  1  first beat of packet.
- EOP_in  in  1  last beat of packet.
- pkt_id_in  in  $clog2(PKT_NUM)  packet ID of beat.
- data_in  in  DATA_WIDTH  beat payload.
- out_vld  out  1  FIFO head holds a packet.
- out_rdy  in  1  consumer accepts head when out_vld & out_rdy.
- out_pkt_id  out  $clog2(PKT_NUM)  ID of head packet.
- out_data  out  PKT_SIZE*DATA_WIDTH  head payload; beat k at [k*DATA_WIDTH +: DATA_WIDTH], SOP at LSB.
- err_clr  in  1  synchronous clear of sticky errors.
- err_seq  out  1  sticky: beat without SOP in IDLE, or SOP mid-packet.
- err_id  out  1  sticky: pkt_id changed mid-packet.
- err_len  out  1  sticky: wrong beat count (early/late EOP, SOP&EOP together).
- drop_cnt  out  8  packets dropped on full FIFO; saturates at 255.
- pkt_cnt  out  16  packets written to FIFO (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset state: FSM IDLE, beat_cnt 0, FIFO empty, out_vld 0, out_data 0, out_pkt_id 0, all err_* 0, drop_cnt 0, pkt_cnt 0.
- Reset mid-packet discards the partial packet and all FIFO contents.
- FSM states: IDLE, BODY. beat_cnt width is $clog2(PKT_SIZE+1). Capture registers hold cur_id and the assembly buffer.
- IDLE, vld_in & SOP_in & !EOP_in: store beat 0, latch cur_id, set beat_cnt=1, go to BODY.
- IDLE, vld_in & !SOP_in: set err_seq; beat ignored.
- IDLE, vld_in & SOP_in & EOP_in: set err_len; beat ignored.
- BODY, vld_in & SOP_in: set err_seq; abandon current packet; treat beat as a new SOP (beat_cnt=1, new cur_id); stay in BODY.
- BODY, vld_in & pkt_id_in != cur_id (non-SOP beat): set err_id; abandon; go to IDLE.
- BODY, middle beat: if beat_cnt == PKT_SIZE-1, set err_len, abandon, go to IDLE; else store at slot beat_cnt and increment beat_cnt.
- BODY, EOP beat: if beat_cnt != PKT_SIZE-1, set err_len, abandon, go to IDLE; else store the last slot, push {cur_id, assembled data} to the FIFO, go to IDLE.
- !vld_in: no state change, no timeout.
- Latency: EOP beat in cycle N gives out_vld=1 in cycle N+1 when the FIFO was empty.
- FIFO is show-ahead: out_data and out_pkt_id are valid whenever out_vld=1 and held stable until popped.
- Full FIFO: push is accepted if the FIFO is not full, or if a pop (out_vld & out_rdy) occurs in the same cycle. Otherwise the packet is dropped and drop_cnt increments (saturating).
- Simultaneous push and pop: occupancy unchanged.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
- Sticky errors: err_clr clears all err_* bits. An error event in the same cycle as err_clr wins (bit stays 1). drop_cnt is not cleared by err_clr.

Optional Feature:
- Macro: PKT_ASSEMBLER_STATS_EN.
- Defined: pkt_cnt counts successful FIFO writes, 16-bit wrapping, reset to 0.
- Undefined: pkt_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- pkt_asm_pkg holds the state_t enum (IDLE, BODY), the ID_W / BEAT_CNT_W localparam functions, and the DROP_CNT_W = 8 / PKT_CNT_W = 16 constants.
- One sub-module: pkt_asm_fifo (synchronous show-ahead FIFO, parameterised width/depth, async active-low reset, push/pop/full/empty).

Test Plan:
- Clean packet: beats (SOP,id=2,d=1),(MOP,id=2,d=0),(EOP,id=2,d=1) in consecutive cycles, out_rdy=1 -> out_vld high one cycle after EOP; out_pkt_id=2; out_data=3'b101; no errors.
- Backpressure and overflow (FIFO_DEPTH=4, out_rdy=0): 6 clean packets -> 4 held in arrival order, drop_cnt=2; then out_rdy=1 -> 4 pops in order, out_vld falls after the 4th.
- Full with simultaneous pop: FIFO full, out_rdy=1 in the EOP cycle of a 5th packet -> packet accepted, drop_cnt unchanged, occupancy stays 4.
- Framing errors: MOP in IDLE -> err_seq=1. SOP id=1 then SOP id=3 -> err_seq=1 and the id=3 packet completes normally. SOP,EOP (2 beats) -> err_len=1, nothing pushed. MOP with a different id -> err_id=1, nothing pushed.
- Sticky clear: err_clr for 1 cycle -> err_* = 0; a repeated violation in the err_clr cycle -> bit stays 1.
- Reset mid-packet: rst_n low after SOP,MOP with 2 packets queued -> out_vld=0 immediately (async); after release, a fresh clean packet assembles correctly. With PKT_ASSEMBLER_STATS_EN, pkt_cnt restarts at 0 and reads 1.
